// File: rtl/tex_addr_gen.sv
// Texel address generator: turns wrapped (u,v) plus mip geometry into one (point)
// or four serial (bilinear) texel byte addresses carrying blend weights and tag.
module tex_addr_gen #(
    parameter int unsigned FRAC_BITS  = 20,
    parameter int unsigned DIM_BITS   = 4,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned TAG_W      = 8,
    parameter int unsigned BLEND_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [FRAC_BITS-1:0]  req_u,
    input  logic [FRAC_BITS-1:0]  req_v,
    input  logic [DIM_BITS-1:0]   req_logw,
    input  logic [DIM_BITS-1:0]   req_logh,
    input  logic [1:0]            req_wrap_u,
    input  logic [1:0]            req_wrap_v,
    input  logic                  req_bilerp,
    input  logic [1:0]            req_stride,
    input  logic [ADDR_W-1:0]     req_base,
    input  logic [TAG_W-1:0]      req_tag,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ADDR_W-1:0]     rsp_addr,
    output logic [1:0]            rsp_idx,
    output logic                  rsp_last,
    output logic [BLEND_BITS-1:0] rsp_alpha,
    output logic [BLEND_BITS-1:0] rsp_beta,
    output logic [TAG_W-1:0]      rsp_tag
);

    localparam int unsigned XW    = (1 << DIM_BITS) - 1;
    localparam int unsigned SU_W  = FRAC_BITS + XW;
    localparam int unsigned OFF_W = 2 * XW + 2;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t                state_q, state_d;
    logic [XW-1:0]         x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
    logic [DIM_BITS-1:0]   logw_q, logw_d;
    logic [1:0]            stride_q, stride_d;
    logic [ADDR_W-1:0]     base_q, base_d;
    logic                  bilerp_q, bilerp_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [ADDR_W-1:0]     rsp_addr_q, rsp_addr_d;
    logic [1:0]            rsp_idx_q, rsp_idx_d;
    logic                  rsp_last_q, rsp_last_d;
    logic [BLEND_BITS-1:0] rsp_alpha_q, rsp_alpha_d;
    logic [BLEND_BITS-1:0] rsp_beta_q, rsp_beta_d;
    logic [TAG_W-1:0]      rsp_tag_q, rsp_tag_d;

    logic [SU_W-1:0]       su, sv;
    logic [XW-1:0]         x0_c, y0_c, wmask, hmask;
    logic [1:0]            stride_c;
    logic [1:0]            idx_n;

    function automatic logic [ADDR_W-1:0] texel_addr(
        input logic [ADDR_W-1:0]   base,
        input logic [XW-1:0]       x,
        input logic [XW-1:0]       y,
        input logic [DIM_BITS-1:0] logw,
        input logic [1:0]          stride
    );
        logic [OFF_W-1:0] lin;
        lin = (OFF_W'(y) << logw) + OFF_W'(x);
        return base + ADDR_W'(lin << stride);
    endfunction

    // Clamp saturates at the edge; every other wrap mode wraps to texel 0.
    function automatic logic [XW-1:0] neighbor(
        input logic [XW-1:0] c,
        input logic [XW-1:0] mask,
        input logic          clamp
    );
        if (clamp) return (c == mask) ? c : c + XW'(1);
        return (c + XW'(1)) & mask;
    endfunction

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_idx   = rsp_idx_q;
    assign rsp_last  = rsp_last_q;
    assign rsp_alpha = rsp_alpha_q;
    assign rsp_beta  = rsp_beta_q;
    assign rsp_tag   = rsp_tag_q;

    always_comb begin
        su       = SU_W'(req_u) << req_logw;
        sv       = SU_W'(req_v) << req_logh;
        x0_c     = XW'(su >> FRAC_BITS);
        y0_c     = XW'(sv >> FRAC_BITS);
        wmask    = ~({XW{1'b1}} << req_logw);
        hmask    = ~({XW{1'b1}} << req_logh);
        stride_c = (req_stride == 2'd3) ? 2'd2 : req_stride;
        idx_n    = rsp_idx_q + 2'd1;

        state_d     = state_q;
        x0_d        = x0_q;
        x1_d        = x1_q;
        y0_d        = y0_q;
        y1_d        = y1_q;
        logw_d      = logw_q;
        stride_d    = stride_q;
        base_d      = base_q;
        bilerp_d    = bilerp_q;
        rsp_valid_d = rsp_valid_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_idx_d   = rsp_idx_q;
        rsp_last_d  = rsp_last_q;
        rsp_alpha_d = rsp_alpha_q;
        rsp_beta_d  = rsp_beta_q;
        rsp_tag_d   = rsp_tag_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d     = EMIT;
                    x0_d        = x0_c;
                    y0_d        = y0_c;
                    x1_d        = neighbor(x0_c, wmask, req_wrap_u == 2'd0);
                    y1_d        = neighbor(y0_c, hmask, req_wrap_v == 2'd0);
                    logw_d      = req_logw;
                    stride_d    = stride_c;
                    base_d      = req_base;
                    bilerp_d    = req_bilerp;
                    rsp_valid_d = 1'b1;
                    rsp_addr_d  = texel_addr(req_base, x0_c, y0_c, req_logw, stride_c);
                    rsp_idx_d   = 2'd0;
                    rsp_last_d  = !req_bilerp;
                    rsp_tag_d   = req_tag;
                    rsp_alpha_d = '0;
                    rsp_beta_d  = '0;
                    if (req_bilerp) begin
                        rsp_alpha_d = BLEND_BITS'(su[FRAC_BITS-1:0] >> (FRAC_BITS - BLEND_BITS));
                        rsp_beta_d  = BLEND_BITS'(sv[FRAC_BITS-1:0] >> (FRAC_BITS - BLEND_BITS));
                    end
                end
            end
            EMIT: begin
                if (rsp_ready) begin
                    if (rsp_last_q) begin
                        state_d     = IDLE;
                        rsp_valid_d = 1'b0;
                    end else begin
                        // idx bit 0 selects the x neighbour, bit 1 the y neighbour
                        rsp_idx_d  = idx_n;
                        rsp_last_d = (idx_n == 2'd3);
                        rsp_addr_d = texel_addr(base_q, idx_n[0] ? x1_q : x0_q,
                                                idx_n[1] ? y1_q : y0_q, logw_q, stride_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            x0_q        <= '0;
            x1_q        <= '0;
            y0_q        <= '0;
            y1_q        <= '0;
            logw_q      <= '0;
            stride_q    <= '0;
            base_q      <= '0;
            bilerp_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_idx_q   <= '0;
            rsp_last_q  <= 1'b0;
            rsp_alpha_q <= '0;
            rsp_beta_q  <= '0;
            rsp_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            x0_q        <= x0_d;
            x1_q        <= x1_d;
            y0_q        <= y0_d;
            y1_q        <= y1_d;
            logw_q      <= logw_d;
            stride_q    <= stride_d;
            base_q      <= base_d;
            bilerp_q    <= bilerp_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_idx_q   <= rsp_idx_d;
            rsp_last_q  <= rsp_last_d;
            rsp_alpha_q <= rsp_alpha_d;
            rsp_beta_q  <= rsp_beta_d;
            rsp_tag_q   <= rsp_tag_d;
        end
    end

endmodule
